// File: rtl/sparse_flg_encoder.sv
// Flag/compressed-value sparse writer: dense elements in, one occupancy flag word per group
// plus a packed stream of the nonzero values. Optional pruning via `FLGENC_PRUNE_EN.
module sparse_flg_encoder #(
  parameter int DATA_WIDTH  = 32,
  parameter int VAL_WIDTH   = 8,
  parameter int CNT_WIDTH   = 6,
  parameter int VFIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  input  logic [VAL_WIDTH-1:0]  in_data,
  input  logic                  in_last,
  output logic                  in_rdy,
  output logic                  val_vld,
  output logic [VAL_WIDTH-1:0]  val_data,
  input  logic                  val_rdy,
  output logic                  flg_vld,
  output logic [DATA_WIDTH-1:0] flg_data,
  output logic [CNT_WIDTH-1:0]  flg_cnt,
  output logic                  flg_last,
  input  logic                  flg_rdy
`ifdef FLGENC_PRUNE_EN
  ,
  input  logic [VAL_WIDTH-1:0]  prune_th
`endif
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam int PTR_W = $clog2(VFIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  state_t                state_r;
  logic [IDX_W-1:0]      idx_r;
  logic [DATA_WIDTH-1:0] flg_acc_r;
  logic [CNT_WIDTH-1:0]  cnt_acc_r;

  logic [VAL_WIDTH-1:0]  mem_r [VFIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [OCC_W-1:0]      occ_r;

  logic                  full_s;
  logic                  accept_s;
  logic                  nz_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  close_s;
  logic [DATA_WIDTH-1:0] flg_next_s;
  logic [CNT_WIDTH-1:0]  cnt_next_s;

`ifdef FLGENC_PRUNE_EN
  // Magnitude is taken one bit wider so the most negative value does not alias.
  function automatic logic keep_elem(input logic [VAL_WIDTH-1:0] d,
                                     input logic [VAL_WIDTH-1:0] th);
    logic [VAL_WIDTH:0] sext;
    logic [VAL_WIDTH:0] mag;
    sext = {d[VAL_WIDTH-1], d};
    if (d[VAL_WIDTH-1]) begin
      mag = ~sext + {{VAL_WIDTH{1'b0}}, 1'b1};
    end else begin
      mag = sext;
    end
    return mag > {1'b0, th};
  endfunction
`else
  function automatic logic keep_elem(input logic [VAL_WIDTH-1:0] d);
    return d != {VAL_WIDTH{1'b0}};
  endfunction
`endif

  // Handshake, element classification and next accumulator values.
  always_comb begin
    full_s   = (occ_r == OCC_W'(VFIFO_DEPTH));
    in_rdy   = rst_n & (state_r == COLLECT) & ~full_s;
    accept_s = in_vld & in_rdy;
`ifdef FLGENC_PRUNE_EN
    nz_s     = keep_elem(in_data, prune_th);
`else
    nz_s     = keep_elem(in_data);
`endif
    push_s   = accept_s & nz_s;
    val_vld  = (occ_r != {OCC_W{1'b0}});
    pop_s    = val_vld & val_rdy;
    close_s  = accept_s & (in_last | (idx_r == IDX_W'(DATA_WIDTH - 1)));
    if (nz_s) begin
      flg_next_s = flg_acc_r | (DATA_WIDTH'(1) << idx_r);
      cnt_next_s = cnt_acc_r + CNT_WIDTH'(1);
    end else begin
      flg_next_s = flg_acc_r;
      cnt_next_s = cnt_acc_r;
    end
    if (val_vld) begin
      val_data = mem_r[rd_ptr_r];
    end else begin
      val_data = {VAL_WIDTH{1'b0}};
    end
  end

  // Value FIFO: storage, wrapping pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VFIFO_DEPTH; i++) begin
        mem_r[i] <= {VAL_WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= in_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Group FSM: collect flags, then hold the flag word until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= COLLECT;
      idx_r     <= {IDX_W{1'b0}};
      flg_acc_r <= {DATA_WIDTH{1'b0}};
      cnt_acc_r <= {CNT_WIDTH{1'b0}};
      flg_vld   <= 1'b0;
      flg_data  <= {DATA_WIDTH{1'b0}};
      flg_cnt   <= {CNT_WIDTH{1'b0}};
      flg_last  <= 1'b0;
    end else begin
      case (state_r)
        COLLECT: begin
          if (accept_s) begin
            idx_r     <= idx_r + IDX_W'(1);
            flg_acc_r <= flg_next_s;
            cnt_acc_r <= cnt_next_s;
            if (close_s) begin
              flg_data <= flg_next_s;
              flg_cnt  <= cnt_next_s;
              flg_last <= in_last;
              flg_vld  <= 1'b1;
              state_r  <= EMIT;
            end
          end
        end
        EMIT: begin
          if (flg_rdy) begin
            flg_vld   <= 1'b0;
            state_r   <= COLLECT;
            idx_r     <= {IDX_W{1'b0}};
            flg_acc_r <= {DATA_WIDTH{1'b0}};
            cnt_acc_r <= {CNT_WIDTH{1'b0}};
          end
        end
        default: begin
          state_r <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_flg_encoder.sv
// Self-checking bench for sparse_flg_encoder: table-driven groups, hand-written stall/reset
// sequences and randomized traffic against a group-level reference model.
module tb_sparse_flg_encoder;
  localparam int DW = 32;
  localparam int VW = 8;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_vld;
  logic [VW-1:0] in_data;
  logic          in_last;
  logic          in_rdy;
  logic          val_vld;
  logic [VW-1:0] val_data;
  logic          val_rdy;
  logic          flg_vld;
  logic [DW-1:0] flg_data;
  logic [CW-1:0] flg_cnt;
  logic          flg_last;
  logic          flg_rdy;
  logic [VW-1:0] prune_th_v = 8'd0;

  always #5 clk = ~clk;

  sparse_flg_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_data(in_data), .in_last(in_last), .in_rdy(in_rdy),
    .val_vld(val_vld), .val_data(val_data), .val_rdy(val_rdy),
    .flg_vld(flg_vld), .flg_data(flg_data), .flg_cnt(flg_cnt), .flg_last(flg_last),
    .flg_rdy(flg_rdy)
`ifdef FLGENC_PRUNE_EN
    , .prune_th(prune_th_v)
`endif
  );

  typedef struct {
    logic [DW-1:0] d;
    int            c;
    bit            l;
  } flg_t;

  typedef struct {
    string          name;
    int             n;
    logic [DW*VW-1:0] elems;
    bit             last;
    logic [DW-1:0]  exp_flg;
    int             exp_cnt;
    bit             exp_last;
  } vec_t;

  int            errors = 0;
  int            checks = 0;
  int            flg_seen = 0;
  int            acc_cnt = 0;
  bit            rand_rdy = 0;
  logic [VW-1:0] grp[$];
  logic [VW-1:0] exp_vals[$];
  flg_t          exp_flg[$];
  flg_t          last_flg;
  vec_t          tbl[6];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endfunction

  // An element survives iff its magnitude exceeds the threshold (0 when pruning is off).
  function automatic bit model_keep(logic [VW-1:0] d);
    int v;
    v = $signed(d);
    if (v < 0) v = -v;
    return v > int'(prune_th_v);
  endfunction

  function automatic flg_t model_close(bit last);
    flg_t f;
    f.d = '0;
    f.c = 0;
    f.l = last;
    foreach (grp[i]) begin
      if (model_keep(grp[i])) begin
        f.d = f.d | (DW'(1) << i);
        f.c++;
      end
    end
    return f;
  endfunction

  // Scoreboard: observes every transfer on the half-cycle before its clock edge.
  always @(negedge clk) begin
    flg_t f;
    if (val_vld && val_rdy) begin
      if (exp_vals.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_value: got %0h, want none", val_data);
      end else begin
        check("val_data", 64'(val_data), 64'(exp_vals.pop_front()));
      end
    end
    if (flg_vld && flg_rdy) begin
      flg_seen++;
      last_flg = '{flg_data, int'(flg_cnt), flg_last};
      if (exp_flg.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_flag: got %0h, want none", flg_data);
      end else begin
        f = exp_flg.pop_front();
        check("flg_data", 64'(flg_data), 64'(f.d));
        check("flg_cnt", 64'(flg_cnt), 64'(f.c));
        check("flg_last", 64'(flg_last), 64'(f.l));
      end
    end
    if (in_vld && in_rdy) begin
      acc_cnt++;
      grp.push_back(in_data);
      if (model_keep(in_data)) exp_vals.push_back(in_data);
      if (grp.size() == DW || in_last) begin
        exp_flg.push_back(model_close(in_last));
        grp.delete();
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) begin
        val_rdy = ($urandom_range(0, 1) != 0);
        flg_rdy = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic send(input logic [VW-1:0] d, input bit last);
    bit done;
    done = 0;
    in_vld = 1'b1; in_data = d; in_last = last;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      if (in_rdy) done = 1;
      else @(posedge clk);
    end
    if (done) begin
      @(posedge clk); #1;
    end else begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_rdy=0, want 1");
    end
    in_vld = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_flg(input int target);
    for (int k = 0; k < 2000 && flg_seen < target; k++) begin
      @(posedge clk); #2;
    end
    check("flag_arrival", 64'(flg_seen >= target), 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 2000 && (exp_vals.size() != 0 || exp_flg.size() != 0); k++) begin
      @(posedge clk); #2;
    end
    check("drain_values", 64'(exp_vals.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_in_rdy"}, 64'(in_rdy), 64'd0);
    check({tag, "_val_vld"}, 64'(val_vld), 64'd0);
    check({tag, "_val_data"}, 64'(val_data), 64'd0);
    check({tag, "_flg_vld"}, 64'(flg_vld), 64'd0);
    check({tag, "_flg_data"}, 64'(flg_data), 64'd0);
    check({tag, "_flg_cnt"}, 64'(flg_cnt), 64'd0);
    check({tag, "_flg_last"}, 64'(flg_last), 64'd0);
  endtask

  initial begin
    int base;
    int len;
    logic [VW-1:0] d;

    tbl[0] = '{"alt32", 32, '0, 1'b0, 32'h5555_5555, 16, 1'b0};
    for (int i = 0; i < DW; i += 2) tbl[0].elems[i*VW +: VW] = VW'(i + 1);
    tbl[1] = '{"partial5", 5, '0, 1'b1, 32'h0000_0012, 2, 1'b1};
    tbl[1].elems[1*VW +: VW] = 8'h07;
    tbl[1].elems[4*VW +: VW] = 8'hFD;
    tbl[2] = '{"one_zero", 1, '0, 1'b1, 32'h0, 0, 1'b1};
    tbl[3] = '{"one_neg", 1, '0, 1'b1, 32'h1, 1, 1'b1};
    tbl[3].elems[0 +: VW] = 8'h80;
    tbl[4] = '{"zeros32", 32, '0, 1'b0, 32'h0, 0, 1'b0};
    tbl[5] = '{"top_last", 32, '0, 1'b1, 32'h8000_0000, 1, 1'b1};
    tbl[5].elems[31*VW +: VW] = 8'h7F;

    rst_n = 1'b0; in_vld = 1'b0; in_data = '0; in_last = 1'b0;
    val_rdy = 1'b1; flg_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    #2 rst_n = 1'b1;
    #1 check("in_rdy_after_reset", 64'(in_rdy), 64'd1);

    foreach (tbl[t]) begin
      base = flg_seen;
      for (int i = 0; i < tbl[t].n; i++)
        send(tbl[t].elems[i*VW +: VW], tbl[t].last && (i == tbl[t].n - 1));
      wait_flg(base + 1);
      check({tbl[t].name, "_flg"}, 64'(last_flg.d), 64'(tbl[t].exp_flg));
      check({tbl[t].name, "_cnt"}, 64'(last_flg.c), 64'(tbl[t].exp_cnt));
      check({tbl[t].name, "_last"}, 64'(last_flg.l), 64'(tbl[t].exp_last));
      drain();
    end

    // Value back-pressure: FIFO fills after four nonzero accepts.
    val_rdy = 1'b0;
    base = flg_seen;
    acc_cnt = 0;
    fork
      for (int i = 0; i < DW; i++) send(VW'(i + 1), 1'b0);
    join_none
    repeat (20) @(posedge clk);
    #1;
    check("bp_accepts", 64'(acc_cnt), 64'd4);
    check("bp_in_rdy", 64'(in_rdy), 64'd0);
    val_rdy = 1'b1;
    wait_flg(base + 1);
    check("bp_flg", 64'(last_flg.d), 64'hFFFF_FFFF);
    check("bp_cnt", 64'(last_flg.c), 64'd32);
    drain();

    // Flag back-pressure: word and in_rdy held, next group starts at bit 0.
    flg_rdy = 1'b0;
    for (int i = 0; i < DW; i++) send(VW'($urandom_range(0, 3)), 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("hold_flg_vld", 64'(flg_vld), 64'd1);
      check("hold_in_rdy", 64'(in_rdy), 64'd0);
      if (exp_flg.size() != 0) check("hold_flg_data", 64'(flg_data), 64'(exp_flg[0].d));
    end
    flg_rdy = 1'b1;
    base = flg_seen;
    send(8'h05, 1'b1);
    wait_flg(base + 2);
    check("restart_flg", 64'(last_flg.d), 64'h1);
    check("restart_cnt", 64'(last_flg.c), 64'd1);
    drain();

    // Asynchronous reset in the middle of a group with values still queued.
    val_rdy = 1'b0;
    for (int i = 0; i < 10; i++) send((i % 4 == 0) ? VW'(i + 9) : VW'(0), 1'b0);
    #2 rst_n = 1'b0;
    grp.delete(); exp_vals.delete(); exp_flg.delete();
    #1 check_reset_outputs("midreset");
    @(posedge clk); #3 rst_n = 1'b1;
    val_rdy = 1'b1;
    base = flg_seen;
    for (int i = 0; i < DW; i++) send(8'h00, 1'b0);
    wait_flg(base + 1);
    check("post_reset_flg", 64'(last_flg.d), 64'h0);
    check("post_reset_cnt", 64'(last_flg.c), 64'd0);
    drain();

`ifdef FLGENC_PRUNE_EN
    prune_th_v = 8'd3;
    base = flg_seen;
    send(8'h02, 1'b0); send(8'hFD, 1'b0); send(8'h04, 1'b0); send(8'h80, 1'b1);
    wait_flg(base + 1);
    check("prune_flg", 64'(last_flg.d), 64'hC);
    check("prune_cnt", 64'(last_flg.c), 64'd2);
    drain();
`endif

    // Randomized groups with random gaps and consumer stalls.
    rand_rdy = 1;
    base = flg_seen;
    for (int g = 0; g < 40; g++) begin
      len = $urandom_range(1, DW);
      for (int i = 0; i < len; i++) begin
        d = ($urandom_range(0, 1) != 0) ? VW'(0) : VW'($urandom);
        send(d, (i == len - 1) && (len < DW || $urandom_range(0, 1) != 0));
        repeat ($urandom_range(0, 1)) @(posedge clk);
        #1;
      end
    end
    wait_flg(base + 40);
    rand_rdy = 0;
    #2;
    val_rdy = 1'b1; flg_rdy = 1'b1;
    drain();
    check("rand_groups", 64'(flg_seen - base), 64'd40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
